// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin arbiter sharing one structural 4:1 mux among 4 requesters
// Optional owner preemption after MAX_HOLD cycles: define MUX41_ARB_TIMEOUT_EN.

module structuralmux41 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] s,
  output logic       y
);

  logic s0_n, s1_n;
  logic a0, a1, a2, a3;

  not g_n0 (s0_n, s[0]);
  not g_n1 (s1_n, s[1]);
  and g_a0 (a0, d0, s1_n, s0_n);
  and g_a1 (a1, d1, s1_n, s[0]);
  and g_a2 (a2, d2, s[1], s0_n);
  and g_a3 (a3, d3, s[1], s[0]);
  or  g_o  (y, a0, a1, a2, a3);

endmodule

module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       y,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD >= (1 << CNT_W)) begin : g_param_check
    $error("MAX_HOLD must be in 1 .. 2**CNT_W-1");
  end

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       s_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] hold_q;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [3:0]       others;
  logic             owner_req;
  logic             timeout;

  // Scan last+1 .. last+3 then last itself, so the previous owner goes to the back.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign others    = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_CAP = CNT_W'(MAX_HOLD - 1);
  assign timeout = (hold_q == HOLD_CAP) && (|others);
`else
  localparam logic [CNT_W-1:0] HOLD_CAP = {CNT_W{1'b1}};
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_idx;
            s_q     <= win_idx;
            last_q  <= win_idx;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || timeout) begin
            // Hand over directly when someone else waits; no idle bubble.
            if (|others) begin
              gnt_q  <= 4'b0001 << win_idx;
              s_q    <= win_idx;
              last_q <= win_idx;
              hold_q <= '0;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              hold_q  <= '0;
            end
          end else if (hold_q != HOLD_CAP) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = |gnt_q;

  structuralmux41 u_mux (
    .d0 (d[0]),
    .d1 (d[1]),
    .d2 (d[2]),
    .d3 (d[3]),
    .s  (s_q),
    .y  (y)
  );

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - scoreboard bench for mux41_rr_arbiter (timeout mode follows MUX41_ARB_TIMEOUT_EN)

module tb_mux41_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       valid;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .s     (s),
    .y     (y),
    .valid (valid)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       v;
    logic       y;
  } exp_t;

  exp_t sb_q[$];

  int         m_owner;
  int         m_last;
  int         m_hold;
  logic [1:0] m_s;

  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
    m_s     = 2'd0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    int cap;
    bit rotate;
`ifdef MUX41_ARB_TIMEOUT_EN
    cap = MAX_HOLD - 1;
`else
    cap = 15;
`endif
    if (m_owner < 0) begin
      w = pick(r);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_hold = 0;
      end
    end else begin
      rotate = !r[m_owner];
`ifdef MUX41_ARB_TIMEOUT_EN
      if (r[m_owner] && m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000)
        rotate = 1'b1;
`endif
      if (rotate) begin
        w = pick(r);
        if (w < 0) m_owner = -1;
        else begin
          m_owner = w; m_last = w; m_hold = 0;
        end
      end else if (m_hold < cap) begin
        m_hold++;
      end
    end
    if (m_owner >= 0) m_s = 2'(m_owner);
  endtask

  task automatic apply(input logic [3:0] r, input logic [3:0] dd);
    exp_t e;
    req = r;
    d   = dd;
    model_step(r);
    e.gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.s   = m_s;
    e.v   = (m_owner >= 0);
    e.y   = dd[m_s];
    sb_q.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("gnt",     8'(gnt),   8'(e.gnt));
    check("s",       8'(s),     8'(e.s));
    check("valid",   8'(valid), 8'(e.v));
    check("y",       8'(y),     8'(e.y));
    check("onehot0", 8'($onehot0(gnt)), 8'd1);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] dd);
    @(negedge clk);
    apply(r, dd);
    collect();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("rst_gnt",   8'(gnt),   8'h0);
    check("rst_s",     8'(s),     8'h0);
    check("rst_valid", 8'(valid), 8'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int gidx(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int own;
    logic [3:0] exp4;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset held with all requesters active.
    rst_n = 1'b0;
    req   = 4'b1111;
    d     = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("t1_rst_gnt",   8'(gnt),   8'h0);
    check("t1_rst_s",     8'(s),     8'h0);
    check("t1_rst_valid", 8'(valid), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1111, 4'b0000);
    collect();
    check("t1_gnt",   8'(gnt),   8'h1);
    check("t1_valid", 8'(valid), 8'h1);

    // Single requester 2, then release.
    step(4'b0100, 4'b0100);
    check("t2_gnt", 8'(gnt), 8'h4);
    check("t2_s",   8'(s),   8'h2);
    check("t2_y",   8'(y),   8'h1);
    step(4'b0000, 4'b0100);
    check("t2_rel_gnt",   8'(gnt),   8'h0);
    check("t2_rel_valid", 8'(valid), 8'h0);

    // All request; each owner drops after two cycles.
    do_reset();
    step(4'b1111, 4'b1010);
    for (int k = 0; k < 5; k++) begin
      own = gidx(gnt);
      check("t3_order", 8'(own), 8'(exp_order[k]));
      step(4'b1111, 4'b1010);
      check("t3_busy", 8'(valid), 8'h1);
      step(4'b1111 & ~(4'b0001 << own), 4'b1010);
      check("t3_busy", 8'(valid), 8'h1);
    end

    // Two competing requesters held.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(4'b0011, 4'b0010);
`ifdef MUX41_ARB_TIMEOUT_EN
      exp4 = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp4 = 4'b0001;
`endif
      check("t4_gnt", 8'(gnt), 8'(exp4));
    end

    // Lone requester is never released.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 4'b0001);
      check("t5_gnt", 8'(gnt), 8'h1);
    end

    // Async reset pulse mid-grant.
    do_reset();
    step(4'b0010, 4'b0010);
    check("t6_pre_gnt", 8'(gnt), 8'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_gnt",   8'(gnt),   8'h0);
    check("t6_s",     8'(s),     8'h0);
    check("t6_valid", 8'(valid), 8'h0);
    model_reset();
    rst_n = 1'b1;
    step(4'b1111, 4'b0001);
    check("t6_first", 8'(gnt), 8'h1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
